// File: rtl/branch_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl_pkg
// Shared definitions for the branch-prediction / redirect controller:
//   - FSM state encoding (IDLE / KILL)
//   - 2-bit saturating counter encodings and the value used on allocation
//   - saturating increment / decrement helpers
// Optional feature macro used by the design: BR_PERF_CNT_EN
// ---------------------------------------------------------------------------
package branch_redirect_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        KILL = 1'b1
    } state_e;

    localparam logic [1:0] CNT_SNT   = 2'b00;   // strongly not taken
    localparam logic [1:0] CNT_WNT   = 2'b01;   // weakly not taken
    localparam logic [1:0] CNT_WT    = 2'b10;   // weakly taken
    localparam logic [1:0] CNT_ST    = 2'b11;   // strongly taken
    localparam logic [1:0] CNT_ALLOC = CNT_WT;  // fresh entry predicts taken

    function automatic logic [1:0] cnt_inc(input logic [1:0] c);
        return (c == CNT_ST) ? CNT_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] cnt_dec(input logic [1:0] c);
        return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl_if
// Bundles the pipeline <-> redirect-controller signals.
//   master : pipeline side (drives stall, fetch PC and execute results)
//   slave  : controller side (drives prediction and redirect/flush)
// Signals:
//   stall, f_pc                            pipeline hold, fetch PC
//   pred_taken, pred_target                fetch-stage prediction
//   x_valid, x_is_br, x_pc, x_should_br,
//   x_target, x_pred_taken, x_pred_target  execute-stage resolution
//   redirect, redirect_pc, flush_fd        PC redirect and fetch/decode kill
// ---------------------------------------------------------------------------
interface branch_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic [XLEN-1:0] f_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            x_valid;
    logic            x_is_br;
    logic [XLEN-1:0] x_pc;
    logic            x_should_br;
    logic [XLEN-1:0] x_target;
    logic            x_pred_taken;
    logic [XLEN-1:0] x_pred_target;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_fd;

    modport master (
        output stall, f_pc,
        output x_valid, x_is_br, x_pc, x_should_br, x_target,
        output x_pred_taken, x_pred_target,
        input  pred_taken, pred_target,
        input  redirect, redirect_pc, flush_fd
    );

    modport slave (
        input  stall, f_pc,
        input  x_valid, x_is_br, x_pc, x_should_br, x_target,
        input  x_pred_taken, x_pred_target,
        output pred_taken, pred_target,
        output redirect, redirect_pc, flush_fd
    );
endinterface

// File: rtl/branch_redirect_ctrl_btb_array.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl_btb_array
// Direct-mapped BTB storage: valid / tag / target / 2-bit counter per entry.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd_idx, rd_tag           async lookup address (fetch side)
//   rd_hit, rd_cnt, rd_target lookup result (pre-write contents)
//   upd_en, upd_idx, upd_tag update request from a resolved branch
//   upd_taken, upd_target    resolved direction and target
// The update port is a read-modify-write: the hit check and the counter
// step are done here against the entry addressed by upd_idx, so the
// controller only needs the single fetch-side read port.
// Reset clears valid bits and sets counters to weakly-not-taken; tags and
// targets are don't-care while invalid and are left unreset.
// ---------------------------------------------------------------------------
module branch_redirect_ctrl_btb_array
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BTB_ENTRIES),
    parameter int TAG_W       = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [1:0]       rd_cnt,
    output logic [XLEN-1:0]  rd_target,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target
);
    logic             valid_reg  [BTB_ENTRIES];
    logic [1:0]       cnt_reg    [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_mem    [BTB_ENTRIES];
    logic [XLEN-1:0]  target_mem [BTB_ENTRIES];

    logic upd_hit;

    assign rd_hit    = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_cnt    = cnt_reg[rd_idx];
    assign rd_target = target_mem[rd_idx];

    assign upd_hit = valid_reg[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    genvar gi;
    generate
        for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    cnt_reg[gi]   <= CNT_WNT;
                end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
                    if (upd_taken) begin
                        valid_reg[gi] <= 1'b1;
                        cnt_reg[gi]   <= upd_hit ? cnt_inc(cnt_reg[gi]) : CNT_ALLOC;
                    end else if (upd_hit) begin
                        cnt_reg[gi]   <= cnt_dec(cnt_reg[gi]);
                    end
                end
            end
        end
    endgenerate

    // Taken updates always (re)write tag and target: on a hit the tag is
    // unchanged, on a miss this is the allocation.
    always_ff @(posedge clk) begin
        if (upd_en && upd_taken) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
// Branch prediction and redirect controller for a three-stage RV32I pipe.
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   bus (slave)     fetch lookup, execute resolution, redirect / flush
//   perf_br_cnt     resolved branches (only with BR_PERF_CNT_EN)
//   perf_mis_cnt    mispredictions    (only with BR_PERF_CNT_EN)
// Optional feature macro: BR_PERF_CNT_EN adds the two 32-bit counters.
// A mispredict asserts redirect/flush_fd combinationally; the following
// KILL cycle keeps flush_fd high to squash the wrong-path word that the
// synchronous instruction memory returns one cycle after the request.
// ---------------------------------------------------------------------------
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_redirect_ctrl_if.slave bus
`ifdef BR_PERF_CNT_EN
    ,
    output logic [31:0]           perf_br_cnt,
    output logic [31:0]           perf_mis_cnt
`endif
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    state_e state_reg, state_next;

    logic            rv;
    logic            mis;
    logic            btb_hit;
    logic [1:0]      btb_cnt;
    logic [XLEN-1:0] btb_target;
    logic [XLEN-1:0] correct_pc;
    logic            redirect_next;
    logic            flush_next;
    logic            unused_pc_lsbs;

    // Instructions are word aligned; the low PC bits carry no index/tag.
    assign unused_pc_lsbs = ^{bus.f_pc[1:0], bus.x_pc[1:0]};

    branch_redirect_ctrl_btb_array #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (bus.f_pc[IDX_W+1:2]),
        .rd_tag     (bus.f_pc[XLEN-1:IDX_W+2]),
        .rd_hit     (btb_hit),
        .rd_cnt     (btb_cnt),
        .rd_target  (btb_target),
        .upd_en     (rv && !bus.stall),
        .upd_idx    (bus.x_pc[IDX_W+1:2]),
        .upd_tag    (bus.x_pc[XLEN-1:IDX_W+2]),
        .upd_taken  (bus.x_should_br),
        .upd_target (bus.x_target)
    );

    assign bus.pred_taken  = btb_hit && btb_cnt[1];
    assign bus.pred_target = btb_hit ? btb_target : '0;

    // Execute-stage inputs are ignored while killing the wrong path.
    assign rv  = bus.x_valid && bus.x_is_br && (state_reg == IDLE);
    assign mis = rv && ((bus.x_should_br != bus.x_pred_taken) ||
                        (bus.x_should_br && (bus.x_target != bus.x_pred_target)));

    assign correct_pc = bus.x_should_br ? bus.x_target : bus.x_pc + XLEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        redirect_next = 1'b0;
        flush_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                redirect_next = mis;
                flush_next    = mis;
                if (mis && !bus.stall) begin
                    state_next = KILL;
                end
            end
            KILL: begin
                flush_next = 1'b1;
                if (!bus.stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so they drop immediately.
    assign bus.redirect    = redirect_next && !rst;
    assign bus.flush_fd    = flush_next && !rst;
    assign bus.redirect_pc = rst ? '0 : correct_pc;

`ifdef BR_PERF_CNT_EN
    logic [31:0] perf_br_reg;
    logic [31:0] perf_mis_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_br_reg  <= '0;
            perf_mis_reg <= '0;
        end else if (!bus.stall) begin
            if (rv) begin
                perf_br_reg <= perf_br_reg + 32'd1;
            end
            if (mis) begin
                perf_mis_reg <= perf_mis_reg + 32'd1;
            end
        end
    end

    assign perf_br_cnt  = perf_br_reg;
    assign perf_mis_cnt = perf_mis_reg;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
// Directed bench for branch_redirect_ctrl. Inputs change 1 ns after the
// rising edge; outputs are checked 1 ns after inputs settle.
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    branch_redirect_ctrl_if #(.XLEN(32)) bus ();

`ifdef BR_PERF_CNT_EN
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mis_cnt;
`endif

    branch_redirect_ctrl #(
        .XLEN        (32),
        .BTB_ENTRIES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave)
`ifdef BR_PERF_CNT_EN
        ,
        .perf_br_cnt  (perf_br_cnt),
        .perf_mis_cnt (perf_mis_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_x(input logic valid, input logic [31:0] pc, input logic sbr,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bus.x_valid       = valid;
        bus.x_is_br       = valid;
        bus.x_pc          = pc;
        bus.x_should_br   = sbr;
        bus.x_target      = tgt;
        bus.x_pred_taken  = ptk;
        bus.x_pred_target = ptgt;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.stall = 1'b0;
        bus.f_pc  = 32'h0;
        drive_x(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset state (inputs would otherwise request a redirect)
        drive_x(1'b1, 32'h100, 1'b1, 32'h140, 1'b0, 32'h0);
        tick();
        check("rst_redirect", {31'd0, bus.redirect}, 32'd0);
        check("rst_flush", {31'd0, bus.flush_fd}, 32'd0);
        check("rst_redir_pc", bus.redirect_pc, 32'h0);
        drive_x(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        tick();

        // Cold lookup
        bus.f_pc = 32'h100;
        #1;
        check("cold_pred_tk", {31'd0, bus.pred_taken}, 32'd0);
        check("cold_pred_tgt", bus.pred_target, 32'h0);
        check("cold_redirect", {31'd0, bus.redirect}, 32'd0);
        check("cold_flush", {31'd0, bus.flush_fd}, 32'd0);

        // First taken branch mispredicted not-taken -> allocate, cnt=10
        drive_x(1'b1, 32'h100, 1'b1, 32'h140, 1'b0, 32'h0);
        check("mis1_redirect", {31'd0, bus.redirect}, 32'd1);
        check("mis1_redir_pc", bus.redirect_pc, 32'h140);
        check("mis1_flush", {31'd0, bus.flush_fd}, 32'd1);
        tick();
        check("kill1_flush", {31'd0, bus.flush_fd}, 32'd1);
        check("kill1_redirect", {31'd0, bus.redirect}, 32'd0);
        check("alloc_pred_tk", {31'd0, bus.pred_taken}, 32'd1);
        check("alloc_pred_tgt", bus.pred_target, 32'h140);
        drive_x(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check("idle1_flush", {31'd0, bus.flush_fd}, 32'd0);

        // Two correctly predicted taken: cnt 10 -> 11 -> 11
        drive_x(1'b1, 32'h100, 1'b1, 32'h140, 1'b1, 32'h140);
        check("tk2_redirect", {31'd0, bus.redirect}, 32'd0);
        tick();
        check("tk3_redirect", {31'd0, bus.redirect}, 32'd0);
        tick();

        // Not taken, predicted taken -> redirect to pc+4, cnt 11 -> 10
        drive_x(1'b1, 32'h100, 1'b0, 32'h140, 1'b1, 32'h140);
        check("nt1_redirect", {31'd0, bus.redirect}, 32'd1);
        check("nt1_redir_pc", bus.redirect_pc, 32'h104);
        tick();
        drive_x(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("nt1_pred_tk", {31'd0, bus.pred_taken}, 32'd1);
        tick();

        // Second not-taken: cnt 10 -> 01, entry stays valid
        drive_x(1'b1, 32'h100, 1'b0, 32'h140, 1'b1, 32'h140);
        check("nt2_redirect", {31'd0, bus.redirect}, 32'd1);
        tick();
        drive_x(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("nt2_pred_tk", {31'd0, bus.pred_taken}, 32'd0);
        check("nt2_pred_tgt", bus.pred_target, 32'h140);
        tick();

        // Mispredict held by stall for 3 cycles
        bus.f_pc  = 32'h208;
        bus.stall = 1'b1;
        drive_x(1'b1, 32'h208, 1'b1, 32'h300, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("stall_redirect", {31'd0, bus.redirect}, 32'd1);
            check("stall_flush", {31'd0, bus.flush_fd}, 32'd1);
            check("stall_pred_tk", {31'd0, bus.pred_taken}, 32'd0);
            tick();
        end
        bus.stall = 1'b0;
        #1;
        check("rel_redirect", {31'd0, bus.redirect}, 32'd1);
        tick();
        drive_x(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rel_kill_flush", {31'd0, bus.flush_fd}, 32'd1);
        check("rel_kill_redir", {31'd0, bus.redirect}, 32'd0);
        check("rel_pred_tk", {31'd0, bus.pred_taken}, 32'd1);
        check("rel_pred_tgt", bus.pred_target, 32'h300);
        tick();
        check("rel_idle_flush", {31'd0, bus.flush_fd}, 32'd0);

        // JALR at top of address space, correctly predicted
        drive_x(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b1, 32'h0);
        check("jalr_redirect", {31'd0, bus.redirect}, 32'd0);
        tick();
        // Not-taken at same PC, predicted taken -> pc+4 wraps to 0
        drive_x(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
        check("wrap_redirect", {31'd0, bus.redirect}, 32'd1);
        check("wrap_redir_pc", bus.redirect_pc, 32'h0);
        tick();
        drive_x(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

`ifdef BR_PERF_CNT_EN
        check("perf_br", perf_br_cnt, 32'd8);
        check("perf_mis", perf_mis_cnt, 32'd5);
`endif

        // Reset in the middle of KILL
        check("kill2_flush", {31'd0, bus.flush_fd}, 32'd1);
        check("pre_rst_pred", {31'd0, bus.pred_taken}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_flush", {31'd0, bus.flush_fd}, 32'd0);
        check("arst_redirect", {31'd0, bus.redirect}, 32'd0);
        check("arst_pred_tk", {31'd0, bus.pred_taken}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_pred", {31'd0, bus.pred_taken}, 32'd0);
        check("post_rst_flush", {31'd0, bus.flush_fd}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Branch-prediction and redirect controller for the three-stage RV32I pipeline.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, used to predict fetch-stage PCs.
- Compares the execute-stage branch-unit result (should_br) against the carried prediction.
- On mismatch, drives PC redirect and fetch/decode flush through a two-state kill sequence that covers synchronous instruction-memory read latency.

Parameters:
XLEN, 32, data/address width.
BTB_ENTRIES, 16, number of BTB entries; power of two, 2..256; IDX_W = log2(BTB_ENTRIES).

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  pipeline hold; freezes FSM and BTB.
f_pc  in  XLEN  PC issued to imem this cycle.
pred_taken  out  1  combinational: BTB hit and counter[1].
pred_target  out  XLEN  combinational: BTB target on hit, else 0.
x_valid  in  1  execute stage holds a real (non-bubble) instruction.
x_is_br  in  1  execute instruction is OPC_BRANCH or OPC_JALR.
x_pc  in  XLEN  execute instruction PC.
x_should_br  in  1  branch-unit taken decision.
x_target  in  XLEN  resolved target address.
x_pred_taken  in  1  prediction carried from fetch.
x_pred_target  in  XLEN  predicted target carried from fetch.
redirect  out  1  select redirect_pc as next PC.
redirect_pc  out  XLEN  correct next PC.
flush_fd  out  1  convert fetch/decode register content to bubble.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; all BTB valid bits = 0; counters = 2'b01.
  - redirect = 0, flush_fd = 0, redirect_pc = 0.
- Lookup (combinational): idx = f_pc[IDX_W+1:2]; tag = f_pc[XLEN-1:IDX_W+2]; hit = valid[idx] and tag match.
- Resolve valid: rv = x_valid and x_is_br and state==IDLE.
- Mispredict: mis = rv and (x_should_br != x_pred_taken, or (x_should_br and x_target != x_pred_target)).
- redirect_pc = x_should_br ? x_target : x_pc+4 (modulo 2^XLEN, wraps).
- FSM:
  - IDLE: redirect = mis and flush_fd = mis, both combinational in the same cycle. If mis and !stall, go to KILL.
  - KILL: redirect = 0, flush_fd = 1. This kills the wrong-path word already requested from sync imem. x_* inputs are ignored.
    - KILL and !stall: go to IDLE.
    - KILL and stall: stay in KILL, flush_fd held high.
- Stall in IDLE with mis: redirect and flush_fd stay asserted, no transition, no BTB write; they re-evaluate each cycle.
- BTB update on rising edge when rv and !stall, index/tag taken from x_pc:
  - Taken, hit: counter saturating +1; target overwritten with x_target.
  - Taken, miss: allocate entry (valid = 1, new tag, target), counter = 2'b10.
  - Not taken, hit: counter saturating -1; entry stays valid.
  - Not taken, miss: no change.
- Same-index read and write in one cycle: pred_* reflect pre-write contents.
- JALR (x_should_br always 1) uses the same path; JAL is not handled here.
- rst asserted mid-KILL: returns to IDLE immediately; outputs go to 0 asynchronously.

Optional Feature:
BR_PERF_CNT_EN:
- Defined: adds outputs perf_br_cnt[31:0] (+1 per rv and !stall) and perf_mis_cnt[31:0] (+1 per mis and !stall). Both wrap at 2^32 and clear on rst.
- Undefined: these ports and their counters are absent.

Decomposition:
- Shared header BranchCtrl.vh: FSM state encodings (IDLE=1'b0, KILL=1'b1), counter constants (CNT_SNT=2'b00, CNT_WNT=2'b01, CNT_WT=2'b10, CNT_ST=2'b11), CNT_ALLOC=CNT_WT.
- One sub-module, btb_array: valid/tag/target/counter storage, one async read port and one sync write port, async clear of valid bits and counters.

Test Plan:
- Reset, then f_pc=0x100 -> pred_taken=0, pred_target=0, redirect=0, flush_fd=0.
- Branch at x_pc=0x100, x_should_br=1, x_target=0x140, x_pred_taken=0 -> redirect=1, redirect_pc=0x140, flush_fd=1 that cycle and the next. Then f_pc=0x100 -> pred_taken=1, pred_target=0x140.
- Same branch resolved taken twice more, then not-taken with x_pred_taken=1 -> counter 10→11→11→10; redirect_pc=0x104; next lookup still pred_taken=1.
- Mispredict with stall=1 for 3 cycles -> redirect and flush_fd held, FSM stays IDLE, BTB unchanged. Release stall -> enters KILL for exactly one cycle.
- JALR at x_pc=0xFFFFFFFC, x_target=0x0, pred correct -> no redirect. Not-taken branch at the same PC mispredicted taken -> redirect_pc=0x00000000 (wrap).
- rst pulsed during KILL -> flush_fd=0 immediately; previously trained PC now gives pred_taken=0.
